// File: rtl/risc_mc_ctrl.sv
// risc_mc_ctrl -- multi-cycle sequencing controller for the 32-bit RISC datapath.
//
// Walks every instruction through FETCH/DECODE/EXEC/MEM/WB so that both the
// instruction and the data memory may stretch an access over any number of
// cycles. The datapath strobes are combinational decodes of the state
// register, the opcode latched in DECODE (op_r) and the same-cycle handshake
// inputs. Because of this, an asynchronous reset clears every strobe
// immediately.
//
// Parameters
//   OP_HALT     opcode that stops the sequencer (default 6'b111111)
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   opcode      IR[31:26], sampled only in DECODE
//   zero        ALU zero flag, sampled only in EXEC of a beq
//   imem_ready  instruction fetch completes this cycle
//   dmem_ready  data access completes this cycle
//   imem_req    fetch request, held until imem_ready
//   ir_en       IR load strobe
//   pc_en       PC load strobe
//   pc_src      PC source: 00 PC+4, 01 branch target, 10 jump target
//   alu_op      ALU control: 00 add, 01 sub, 10 funct
//   wr1         register-file write
//   sel2        register destination: 0 rt, 1 rd
//   sel3        ALU B input: 0 rt_data, 1 sign-extended immediate
//   sel4        write-back source: 0 ALU, 1 memory
//   cs/rd2/wr2  data-memory select, read and write
//   branch      beq in EXEC
//   state       current state, for debug
//   halted      sequencer stopped
//   illegal     stopped on an undecoded opcode
// Optional feature (macro RISC_MC_PERF_EN)
//   cycle_cnt   active (non IDLE/HALT) cycles, wraps at 2^32
//   instr_cnt   completed instructions, wraps at 2^32
module risc_mc_ctrl #(
  parameter logic [5:0] OP_HALT = 6'b111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_en,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       wr1,
  output logic       sel2,
  output logic       sel3,
  output logic       sel4,
  output logic       cs,
  output logic       rd2,
  output logic       wr2,
  output logic       branch,
  output logic [2:0] state,
  output logic       halted,
  output logic       illegal
`ifdef RISC_MC_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [2:0] state_r;
  logic [2:0] state_s;
  logic [5:0] op_r;          // opcode latched in DECODE (op_q)
  logic       illegal_r;
  logic       bad_op_s;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J) || (op == OP_HALT);
  endfunction

  assign bad_op_s = (state_r == ST_DECODE) && !is_legal(opcode);

  // Next-state decode; ready inputs only matter in their own wait state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = ST_FETCH;
      ST_FETCH:  begin
        if (imem_ready) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_J) begin
          state_s = ST_FETCH;
        end else if ((opcode == OP_HALT) || !is_legal(opcode)) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_r)
          OP_RTYPE, OP_ADDI: state_s = ST_WB;
          OP_LW, OP_SW:      state_s = ST_MEM;
          default:           state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!dmem_ready) begin
          state_s = ST_MEM;
        end else if (op_r == OP_LW) begin
          state_s = ST_WB;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_WB:   state_s = ST_FETCH;
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Opcode latch, loaded only while in DECODE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r <= 6'b000000;
    end else if (state_r == ST_DECODE) begin
      op_r <= opcode;
    end else begin
      op_r <= op_r;
    end
  end

  // Sticky flag recording that the halt came from an undecoded opcode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_r <= 1'b0;
    end else if (bad_op_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Datapath strobe decode; ALU and mux selects stay put from EXEC through WB.
  always_comb begin
    imem_req = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_src   = 2'b00;
    alu_op   = 2'b00;
    wr1      = 1'b0;
    sel2     = 1'b0;
    sel3     = 1'b0;
    sel4     = 1'b0;
    cs       = 1'b0;
    rd2      = 1'b0;
    wr2      = 1'b0;
    branch   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en = 1'b1;
          pc_en = 1'b1;
        end else begin
          ir_en = 1'b0;
        end
      end
      ST_DECODE: begin
        // j resolves here, so it reads the live opcode rather than op_r.
        if (opcode == OP_J) begin
          pc_en  = 1'b1;
          pc_src = 2'b10;
        end else begin
          pc_en = 1'b0;
        end
      end
      ST_EXEC: begin
        case (op_r)
          OP_RTYPE: alu_op = 2'b10;
          OP_LW, OP_SW, OP_ADDI: begin
            alu_op = 2'b00;
            sel3   = 1'b1;
          end
          OP_BEQ: begin
            alu_op = 2'b01;
            branch = 1'b1;
            if (zero) begin
              pc_en  = 1'b1;
              pc_src = 2'b01;
            end else begin
              pc_en = 1'b0;
            end
          end
          default: alu_op = 2'b00;
        endcase
      end
      ST_MEM: begin
        cs   = 1'b1;
        sel3 = 1'b1;
        rd2  = (op_r == OP_LW);
        wr2  = (op_r == OP_SW);
      end
      ST_WB: begin
        case (op_r)
          OP_RTYPE: begin
            wr1    = 1'b1;
            alu_op = 2'b10;
            sel2   = 1'b1;
          end
          OP_LW: begin
            wr1  = 1'b1;
            sel3 = 1'b1;
            sel4 = 1'b1;
          end
          OP_ADDI: begin
            wr1  = 1'b1;
            sel3 = 1'b1;
          end
          default: wr1 = 1'b0;
        endcase
      end
      default: imem_req = 1'b0;
    endcase
  end

  assign state   = state_r;
  assign halted  = (state_r == ST_HALT);
  assign illegal = illegal_r;

`ifdef RISC_MC_PERF_EN
  logic        instr_done_s;
  logic        active_s;
  logic [31:0] cycle_cnt_r;
  logic [31:0] instr_cnt_r;

  // Completion points: WB exit, sw MEM exit, beq EXEC exit, j DECODE exit.
  always_comb begin
    active_s     = (state_r != ST_IDLE) && (state_r != ST_HALT);
    instr_done_s = (state_r == ST_WB) ||
                   ((state_r == ST_MEM) && dmem_ready && (op_r == OP_SW)) ||
                   ((state_r == ST_EXEC) && (op_r == OP_BEQ)) ||
                   ((state_r == ST_DECODE) && (opcode == OP_J));
  end

  // Active-cycle counter; naturally frozen in IDLE and HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_r <= 32'd0;
    end else if (active_s) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  // Retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_r <= 32'd0;
    end else if (instr_done_s) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_risc_mc_ctrl.sv
// Scoreboard bench for risc_mc_ctrl. The driver plays each instruction as a
// per-cycle plan built from the instruction's phase list and pushes the
// expected output vector of every cycle into a queue. A separate monitor pops
// and compares on each falling edge. Inputs that must be ignored are randomized.
module tb_risc_mc_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       wr1;
    logic       sel2;
    logic       sel3;
    logic       sel4;
    logic       cs;
    logic       rd2;
    logic       wr2;
    logic       branch;
    logic [2:0] state;
    logic       halted;
    logic       illegal;
  } outs_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HLT  = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b010101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, ir_en, pc_en, wr1, sel2, sel3, sel4, cs, rd2, wr2, branch, halted, illegal;
  logic [1:0] pc_src, alu_op;
  logic [2:0] state;
`ifdef RISC_MC_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
  int exp_cycles = 0;
  int exp_instrs = 0;
`endif

  int checks = 0;
  int failures = 0;
  outs_t exp_q[$];
  outs_t mon_a, mon_e;
  logic ill_exp = 1'b0;
  logic [5:0] legal_ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

  risc_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src),
    .alu_op(alu_op), .wr1(wr1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
    .cs(cs), .rd2(rd2), .wr2(wr2), .branch(branch), .state(state),
    .halted(halted), .illegal(illegal)
`ifdef RISC_MC_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic outs_t cur_outs();
    return {imem_req, ir_en, pc_en, pc_src, alu_op, wr1, sel2, sel3, sel4,
            cs, rd2, wr2, branch, state, halted, illegal};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  // Monitor: compares the DUT against the oldest pending expectation.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = cur_outs();
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, mon_a, mon_e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  // One cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic step(input logic [5:0] op_v, input logic z, input logic im,
                      input logic dm, input outs_t e);
    @(posedge clk);
    #1;
    opcode = op_v; zero = z; imem_ready = im; dmem_ready = dm;
    exp_q.push_back(e);
`ifdef RISC_MC_PERF_EN
    if (e.state != 3'd0 && e.state != 3'd6) exp_cycles++;
`endif
  endtask

  task automatic do_reset();
    outs_t e;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(cur_outs()), 32'd0);
`ifdef RISC_MC_PERF_EN
    chk("reset_cycle_cnt", cycle_cnt, 32'd0);
    chk("reset_instr_cnt", instr_cnt, 32'd0);
    exp_cycles = 0;
    exp_instrs = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    opcode = rop(); zero = rbit(); imem_ready = rbit(); dmem_ready = rbit();
    e = '0;
    exp_q.push_back(e);
  endtask

  task automatic instr_retired();
`ifdef RISC_MC_PERF_EN
    exp_instrs++;
`endif
  endtask

  // Reference sequence for one instruction: fetch (iw waits), decode, then the
  // class-specific tail. abort_mem pulls reset during the first MEM wait.
  task automatic run_instr(input logic [5:0] op, input int iw, input int dw,
                           input logic z, input bit abort_mem);
    outs_t e;
    logic is_mem;
    for (int i = 0; i < iw; i++) begin
      e = '0; e.state = 3'd1; e.imem_req = 1'b1;
      step(rop(), rbit(), 1'b0, rbit(), e);
    end
    e = '0; e.state = 3'd1; e.imem_req = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1;
    step(rop(), rbit(), 1'b1, rbit(), e);

    e = '0; e.state = 3'd2;
    if (op == OP_J) begin
      e.pc_en = 1'b1; e.pc_src = 2'b10;
    end
    step(op, rbit(), rbit(), rbit(), e);
    if (op == OP_J) begin
      instr_retired();
      return;
    end
    if (op == OP_HLT) begin
      ill_exp = 1'b0;
      return;
    end
    if (!(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI})) begin
      ill_exp = 1'b1;
      return;
    end

    e = '0; e.state = 3'd3;
    if (op == OP_R) begin
      e.alu_op = 2'b10;
    end else if (op == OP_BEQ) begin
      e.alu_op = 2'b01; e.branch = 1'b1;
      e.pc_en = z; e.pc_src = z ? 2'b01 : 2'b00;
    end else begin
      e.sel3 = 1'b1;
    end
    step(rop(), (op == OP_BEQ) ? z : rbit(), rbit(), rbit(), e);
    if (op == OP_BEQ) begin
      instr_retired();
      return;
    end

    is_mem = (op == OP_LW) || (op == OP_SW);
    if (is_mem) begin
      e = '0; e.state = 3'd4; e.cs = 1'b1; e.sel3 = 1'b1;
      e.rd2 = (op == OP_LW); e.wr2 = (op == OP_SW);
      for (int i = 0; i < dw; i++) begin
        step(rop(), rbit(), rbit(), 1'b0, e);
        if (abort_mem) begin
          do_reset();
          return;
        end
      end
      step(rop(), rbit(), rbit(), 1'b1, e);
      if (op == OP_SW) begin
        instr_retired();
        return;
      end
    end

    e = '0; e.state = 3'd5; e.wr1 = 1'b1;
    if (op == OP_R) begin
      e.alu_op = 2'b10; e.sel2 = 1'b1;
    end else begin
      e.sel3 = 1'b1; e.sel4 = (op == OP_LW);
    end
    step(rop(), rbit(), rbit(), rbit(), e);
    instr_retired();
  endtask

  task automatic halt_cycles(input int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.state = 3'd6; e.halted = 1'b1; e.illegal = ill_exp;
      step(rop(), rbit(), rbit(), rbit(), e);
    end
  endtask

  task automatic perf_check();
    @(negedge clk);
    #1;
`ifdef RISC_MC_PERF_EN
    chk("cycle_cnt", cycle_cnt, 32'(exp_cycles));
    chk("instr_cnt", instr_cnt, 32'(exp_instrs));
`endif
  endtask

  initial begin
    #2;
    do_reset();
    run_instr(OP_R,    0, 0, 1'b0, 1'b0);
    run_instr(OP_LW,   0, 3, 1'b0, 1'b0);
    run_instr(OP_BEQ,  0, 0, 1'b1, 1'b0);
    run_instr(OP_BEQ,  1, 0, 1'b0, 1'b0);
    run_instr(OP_SW,   2, 1, 1'b0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
    run_instr(OP_J,    0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), rbit(), 1'b0);
    end
    run_instr(OP_BAD, 0, 0, 1'b0, 1'b0);
    halt_cycles(10);
    perf_check();

    do_reset();
    run_instr(OP_ADDI, 1, 0, 1'b0, 1'b0);
    run_instr(OP_SW,   0, 2, 1'b0, 1'b1);
    perf_check();

    run_instr(OP_R,   0, 0, 1'b0, 1'b0);
    run_instr(OP_J,   1, 0, 1'b0, 1'b0);
    run_instr(OP_HLT, 0, 0, 1'b0, 1'b0);
    halt_cycles(5);
    perf_check();

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
